// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: bus width, funct3 access codes,
// FSM state encoding and small size/alignment helpers.
package load_store_unit_pkg;

  localparam int unsigned XLEN = 64;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_D  = 3'b011,
    F3_BU = 3'b100,
    F3_HU = 3'b101,
    F3_WU = 3'b110
  } funct3_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // size is funct3[1:0]: 0=byte, 1=half, 2=word, 3=double
  function automatic logic is_aligned(input logic [1:0] size, input logic [2:0] offset);
    case (size)
      2'b00:   is_aligned = 1'b1;
      2'b01:   is_aligned = ~offset[0];
      2'b10:   is_aligned = (offset[1:0] == 2'b00);
      default: is_aligned = (offset == 3'b000);
    endcase
  endfunction

  function automatic logic [7:0] size_mask(input logic [1:0] size);
    case (size)
      2'b00:   size_mask = 8'h01;
      2'b01:   size_mask = 8'h03;
      2'b10:   size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_load_extend.sv
// Moves the addressed bytes of a 64-bit bus word down to bit 0, then
// truncates and sign/zero-extends according to funct3.
module load_extend
  import load_store_unit_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      offset,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] result
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    result  = shifted;
    case (funct3)
      F3_B:    result = {{56{shifted[7]}},  shifted[7:0]};
      F3_H:    result = {{48{shifted[15]}}, shifted[15:0]};
      F3_W:    result = {{32{shifted[31]}}, shifted[31:0]};
      F3_BU:   result = {56'b0, shifted[7:0]};
      F3_HU:   result = {48'b0, shifted[15:0]};
      F3_WU:   result = {32'b0, shifted[31:0]};
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: checks alignment, launches one bus
// transaction, waits for ack, and returns an extended load result.
module load_store_unit
  import load_store_unit_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_mem_read,
  input  logic            i_mem_write,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_addr,
  input  logic [XLEN-1:0] i_wdata,
  output logic            o_bus_req,
  output logic            o_bus_we,
  output logic [XLEN-1:0] o_bus_addr,
  output logic [XLEN-1:0] o_bus_wdata,
  output logic [7:0]      o_bus_be,
  input  logic            i_bus_ack,
  input  logic [XLEN-1:0] i_bus_rdata,
  output logic            o_stall,
  output logic [XLEN-1:0] o_rdata,
  output logic            o_rdata_valid,
  output logic            o_misaligned
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic [7:0]      be_q, be_d;
  logic            we_q, we_d;
  logic [2:0]      off_q, off_d;
  logic [2:0]      f3_q, f3_d;

  logic            access;
  logic            aligned;
  logic            stall;
  logic            misaligned;
  logic [XLEN-1:0] load_result;

  load_extend u_load_extend (
    .rdata  (i_bus_rdata),
    .offset (off_q),
    .funct3 (f3_q),
    .result (load_result)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    be_d       = be_q;
    we_d       = we_q;
    off_d      = off_q;
    f3_d       = f3_q;
    stall      = 1'b0;
    misaligned = 1'b0;
    access     = i_mem_read | i_mem_write;
    aligned    = is_aligned(i_funct3[1:0], i_addr[2:0]);

    case (state_q)
      ST_IDLE: begin
        if (access && aligned) begin
          stall   = 1'b1;
          state_d = ST_BUS;
          // read+write together resolves to a write
          we_d    = i_mem_write;
          addr_d  = {i_addr[XLEN-1:3], 3'b000};
          off_d   = i_addr[2:0];
          f3_d    = i_funct3;
          be_d    = size_mask(i_funct3[1:0]) << i_addr[2:0];
          case (i_funct3[1:0])
            2'b00:   wdata_d = {8{i_wdata[7:0]}};
            2'b01:   wdata_d = {4{i_wdata[15:0]}};
            2'b10:   wdata_d = {2{i_wdata[31:0]}};
            default: wdata_d = i_wdata;
          endcase
        end else if (access) begin
          misaligned = 1'b1;
        end
      end
      ST_BUS: begin
        stall = 1'b1;
        if (i_bus_ack) begin
          state_d = ST_DONE;
          if (!we_q) rdata_d = load_result;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      off_q   <= '0;
      f3_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      be_q    <= be_d;
      we_q    <= we_d;
      off_q   <= off_d;
      f3_q    <= f3_d;
    end
  end

  assign o_bus_req     = (state_q == ST_BUS);
  assign o_bus_we      = we_q;
  assign o_bus_addr    = addr_q;
  assign o_bus_wdata   = wdata_q;
  assign o_bus_be      = be_q;
  assign o_rdata       = rdata_q;
  assign o_rdata_valid = (state_q == ST_DONE) && !we_q;
  // combinational strobes are masked while reset is held
  assign o_stall       = stall & ~i_reset;
  assign o_misaligned  = misaligned & ~i_reset;

endmodule
